result_display: RTL
===================

# result_display

Display back end for the arithmetic datapath. It captures a 16-bit result word on a load strobe and converts it to sign plus three BCD digits with a sequential shift-add-3 (double-dabble) engine. It then drives a four-digit, time-multiplexed, active-low seven-segment display. It sits downstream of the arithmetic unit's `ans` output, and its `is_signed` input selects the add/subtract (two's complement) or multiply (unsigned) interpretation.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit stays lit; must be ≥ 2.
- `clock`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-low; clears all state immediately.
- `ans`  in  16: result word; sampled only on an accepted load.
- `is_signed`  in  1: 1 means `ans` is two's complement; 0 means unsigned. Sampled with `ans`.
- `load`  in  1: single-cycle request to convert and show `ans`. Ignored while `busy`=1.
- `busy`  out  1: conversion in progress. Registered.
- `ovf`  out  1: displayed magnitude exceeds 999; display shows dashes. Registered.
- `an`  out  4: digit enables, active-low, one-hot-zero; bit 0 is the units digit and bit 3 is the sign digit. Registered.
- `seg`  out  7: segments `{g,f,e,d,c,b,a}`, active-low. Registered.

## Operation
- **FSM states:** IDLE, CONV, FINISH.
- **IDLE:**
  - On `load`=1, capture `ans` and `is_signed`.
  - Form the 16-bit magnitude: if `is_signed` and `ans[15]`=1, use `-ans` and set the neg flag; otherwise use `ans` unchanged. 16'h8000 gives magnitude 32768.
  - Clear the 20-bit BCD register, load the 5-bit iteration counter with 0, and go to CONV.
- **CONV (one iteration per cycle):**
  - Add 3 to every BCD nibble that is ≥ 5.
  - Shift `{bcd, mag}` left by 1.
  - Increment the counter. After the 16th iteration, go to FINISH.
- **FINISH:**
  - If BCD digits 4 or 3 are nonzero, set `ovf`=1. Otherwise set `ovf`=0.
  - Copy the hundreds, tens, units and neg flag into the display registers.
  - Return to IDLE.
- **Digit content (no overflow):**
  - Digit 3 shows minus (`seg`=0111111) when neg, else blank (1111111).
  - Digit 2 shows hundreds, blank if zero.
  - Digit 1 shows tens, blank if both hundreds and tens are zero.
  - Digit 0 always shows units.
- **Digit content (ovf=1):** all four digits show minus/dash (0111111).
- **Segment codes:** 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- **Refresh:**
  - A counter runs 0..REFRESH_DIV-1 continuously and is independent of the FSM.
  - At terminal count it wraps to 0 and the digit index advances 0→1→2→3→0.
  - `an`/`seg` are registered from the current index and display registers every cycle.
- **Display update:** display registers change only in FINISH, so the old value stays visible during CONV (no flicker or partial values).

## Timing
- **Reset values (asynchronous):**
  - FSM = IDLE; `busy`=0; `ovf`=0.
  - Display registers hold value 0, non-negative.
  - Refresh counter and digit index = 0.
  - `an`=1111; `seg`=1111111.
- **First edge after reset release:** `an`=1110, `seg`=1000000.
- **Load latency:**
  - Load is sampled at edge E0.
  - `busy`=1 after E0.
  - CONV iterations occur on edges E1..E16.
  - FINISH occurs on E17: display registers and `ovf` update, and `busy`=0 after E17.
  - New digits appear on `an`/`seg` at E18.
- **Load acceptance:**
  - The earliest next load is sampled at E18.
  - `load` during `busy` is dropped, not queued.
  - `load` held high in IDLE starts a new conversion every 18 cycles.
- **Digit dwell:** each digit is active for exactly REFRESH_DIV cycles. `an` changes one cycle after terminal count.
- **Reset during CONV/FINISH:** the conversion is aborted and all registers return to their reset values. No partial result is ever displayed.
- **Simultaneous terminal count and FINISH:** the new digit index uses the new display registers on the next edge.

## Test plan
1. **Reset:** assert `reset`=0 with REFRESH_DIV=4, then release. Required: `an`=1111, `seg`=1111111 and `busy`=0 during reset. Then `an`=1110, `seg`=1000000. Digits 1–3 read 1111111 when scanned.
2. **Unsigned 225:** `ans`=16'd225, `is_signed`=0, one-cycle `load`. Required: `busy` high for exactly 17 cycles, then `ovf`=0. Digits d3..d0 = 1111111, 0100100, 0100100, 0010010.
3. **Signed -13:** `ans`=16'hFFF3, `is_signed`=1. Required: d3=0111111, d2=1111111, d1=1111001, d0=0110000, `ovf`=0. Repeat with `is_signed`=0: `ovf`=1 (65523) and all digits 0111111.
4. **Boundary values:** `ans`=999 unsigned gives 9,9,9 with `ovf`=0. `ans`=1000 unsigned gives `ovf`=1 and all dashes. `ans`=16'h8000 signed gives `ovf`=1. `ans`=0 gives only d0=1000000.
5. **Load while busy and reset abort:**
   - Second `load` with `ans`=7 at E5 of a 225 conversion: ignored, display ends at 225.
   - `reset` pulsed at E8 of a conversion: `busy`=0 immediately; display shows 0 after release.
6. **Refresh rotation, REFRESH_DIV=4:** required `an` sequence 1110, 1101, 1011, 0111, 1110, each held exactly 4 cycles, with no cycle having more than one low bit.

Source files
------------

// File: rtl/result_display_if.sv
// Bus between the arithmetic unit and the result display: result word plus load strobe in, status and display drive out.
interface result_display_if;
    logic [15:0] ans;
    logic        is_signed;
    logic        load;
    logic        busy;
    logic        ovf;
    logic [3:0]  an;
    logic [6:0]  seg;

    modport master (
        output ans, is_signed, load,
        input  busy, ovf, an, seg
    );

    modport slave (
        input  ans, is_signed, load,
        output busy, ovf, an, seg
    );
endinterface

// File: rtl/result_display.sv
// Converts a captured 16-bit result to sign + three BCD digits (double dabble)
// and scans it onto a four-digit active-low seven-segment display.
module result_display #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic              clock,
    input  logic              reset,
    result_display_if.slave   bus
);
    localparam int unsigned MAG_W = 16;
    localparam int unsigned BCD_W = 20;
    localparam int unsigned CNT_W = 5;
    localparam int unsigned REF_W = $clog2(REFRESH_DIV);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {IDLE, CONV, FINISH} state_t;

    state_t             state_q, state_d;
    logic [MAG_W-1:0]   mag_q, mag_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic               busy_q, busy_d;
    logic               ovf_q, ovf_d;
    logic [3:0]         hun_q, hun_d, ten_q, ten_d, unit_q, unit_d;
    logic               dneg_q, dneg_d;

    logic [REF_W-1:0]   ref_q, ref_d;
    logic [1:0]         dig_q, dig_d;
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = SEG_BLANK;
        endcase
    endfunction

    // Conversion FSM state and datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            mag_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            hun_q   <= '0;
            ten_q   <= '0;
            unit_q  <= '0;
            dneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            hun_q   <= hun_d;
            ten_q   <= ten_d;
            unit_q  <= unit_d;
            dneg_q  <= dneg_d;
        end
    end

    // Next-state and datapath: capture, 16 shift-add-3 iterations, publish
    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        hun_d   = hun_q;
        ten_d   = ten_q;
        unit_d  = unit_q;
        dneg_d  = dneg_q;
        bcd_adj = bcd_q;

        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    neg_d   = bus.is_signed & bus.ans[15];
                    mag_d   = (bus.is_signed & bus.ans[15]) ? MAG_W'(~bus.ans + 16'd1) : bus.ans;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                for (int i = 0; i < 5; i++) begin
                    if (bcd_q[4*i +: 4] >= 4'd5)
                        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
                end
                {bcd_d, mag_d} = (BCD_W + MAG_W)'({bcd_adj, mag_q} << 1);
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(15))
                    state_d = FINISH;
            end
            FINISH: begin
                ovf_d   = |bcd_q[19:12];
                hun_d   = bcd_q[11:8];
                ten_d   = bcd_q[7:4];
                unit_d  = bcd_q[3:0];
                dneg_d  = neg_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // Refresh scan registers, free-running and independent of the FSM
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ref_q <= '0;
            dig_q <= '0;
            an_q  <= 4'b1111;
            seg_q <= SEG_BLANK;
        end else begin
            ref_q <= ref_d;
            dig_q <= dig_d;
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    // Digit select and segment content from the published display registers
    always_comb begin
        ref_d = ref_q + REF_W'(1);
        dig_d = dig_q;
        if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
            ref_d = '0;
            dig_d = dig_q + 2'd1;
        end

        an_d          = 4'b1111;
        an_d[dig_q]   = 1'b0;
        seg_d         = SEG_BLANK;

        if (ovf_q) begin
            seg_d = SEG_DASH;
        end else begin
            case (dig_q)
                2'd3:    seg_d = dneg_q ? SEG_DASH : SEG_BLANK;
                2'd2:    seg_d = (hun_q == 4'd0) ? SEG_BLANK : seg_code(hun_q);
                2'd1:    seg_d = (hun_q == 4'd0 && ten_q == 4'd0) ? SEG_BLANK : seg_code(ten_q);
                default: seg_d = seg_code(unit_q);
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.ovf  = ovf_q;
    assign bus.an   = an_q;
    assign bus.seg  = seg_q;
endmodule
